// File: rtl/regbus_sequencer_pkg.sv
// Shared definitions for the register-bus micro-sequencer: widths, opcodes,
// ALU selects, FSM state encoding and the decoded control-vector layout.
package regbus_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int RSEL_W = 3;
  localparam int CNT_W  = 16;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Operation fields captured when an op is accepted out of IDLE
  typedef struct packed {
    logic [2:0]        opcode;
    logic [RSEL_W-1:0] rd;
    logic [RSEL_W-1:0] rs1;
    logic [RSEL_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
  } fields_t;

  // Every strobe the sequencer presents, produced by the state decoder
  typedef struct packed {
    logic              busy;
    logic              done;
    logic              err;
    logic [RSEL_W-1:0] rsel;
    logic              wrr;
    logic              tr;
    logic              la;
    logic              ta;
    logic              lb;
    logic              lz;
    logic              tz;
    logic              alu_t;
    logic              alu_op;
    logic              sflag;
    logic              imm_t;
  } ctl_t;

  // Opcodes 101..111 have no defined operation
  function automatic logic isLegal(input logic [2:0] op);
    return (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/regbus_sequencer_if.sv
// Handshake and bus-control bundle between an op issuer and the sequencer.
interface regbus_sequencer_if;
  import regbus_sequencer_pkg::*;

  logic              start;
  logic [2:0]        opcode;
  logic [RSEL_W-1:0] rd;
  logic [RSEL_W-1:0] rs1;
  logic [RSEL_W-1:0] rs2;
  logic [DATA_W-1:0] imm;

  logic              busy;
  logic              done;
  logic              err;
  logic [RSEL_W-1:0] rsel;
  logic              wrr;
  logic              tr;
  logic              la;
  logic              ta;
  logic              lb;
  logic              lz;
  logic              tz;
  logic              alu_t;
  logic              alu_op;
  logic              sflag;
  logic [DATA_W-1:0] imm_out;
  logic              imm_t;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output start, opcode, rd, rs1, rs2, imm,
    input  busy, done, err, rsel, wrr, tr, la, ta, lb, lz, tz,
           alu_t, alu_op, sflag, imm_out, imm_t, op_count
  );

  modport slave (
    input  start, opcode, rd, rs1, rs2, imm,
    output busy, done, err, rsel, wrr, tr, la, ta, lb, lz, tz,
           alu_t, alu_op, sflag, imm_out, imm_t, op_count
  );

endinterface

// File: rtl/regbus_ctl_decode.sv
// Combinational Moore decoder: current state plus latched op fields to the
// full control vector. Each state enables at most one bus driver.
module regbus_ctl_decode
  import regbus_sequencer_pkg::*;
(
  input  state_e            state_i,
  input  logic [2:0]        opcode_i,
  input  logic [RSEL_W-1:0] rd_i,
  input  logic [RSEL_W-1:0] rs1_i,
  input  logic [RSEL_W-1:0] rs2_i,
  output ctl_t              ctl_o
);

  // Strobes per micro-step; anything not named for a state stays 0
  always_comb begin
    ctl_o      = '0;
    ctl_o.busy = (state_i != ST_IDLE);
    unique case (state_i)
      ST_IDLE: ;
      ST_RDA: begin
        ctl_o.rsel = rs1_i;
        ctl_o.tr   = 1'b1;
        ctl_o.la   = 1'b1;
      end
      ST_RDB: begin
        ctl_o.rsel = rs2_i;
        ctl_o.tr   = 1'b1;
        ctl_o.lb   = 1'b1;
      end
      ST_EXEC: begin
        ctl_o.alu_t  = 1'b1;
        ctl_o.alu_op = (opcode_i == OP_SUB || opcode_i == OP_CMP) ? ALU_SUB : ALU_ADD;
        ctl_o.lz     = 1'b1;
        ctl_o.sflag  = 1'b1;
        ctl_o.done   = (opcode_i == OP_CMP);
      end
      ST_WB: begin
        ctl_o.rsel = rd_i;
        ctl_o.wrr  = 1'b1;
        ctl_o.done = 1'b1;
        unique case (opcode_i)
          OP_LDI:         ctl_o.imm_t = 1'b1;
          OP_MOV:         ctl_o.ta    = 1'b1;
          OP_ADD, OP_SUB: ctl_o.tz    = 1'b1;
          default: ;
        endcase
      end
      ST_ERR: begin
        ctl_o.done = 1'b1;
        ctl_o.err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regbus_sequencer.sv
// Register-transfer micro-sequencer: accepts one op at a time, walks it
// through read/execute/write-back steps over the shared bus, and counts
// completed legal ops.
module regbus_sequencer
  import regbus_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  regbus_sequencer_if.slave  sif
);

  state_e           state_q, state_d;
  fields_t          fields_q, fields_d;
  logic [CNT_W-1:0] opCount_q, opCount_d;
  ctl_t             ctl;

  // Sequence selection at acceptance, then a fixed walk to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sif.start) begin
          if (!isLegal(sif.opcode))      state_d = ST_ERR;
          else if (sif.opcode == OP_LDI) state_d = ST_WB;
          else                           state_d = ST_RDA;
        end
      end
      ST_RDA:  state_d = (fields_q.opcode == OP_MOV) ? ST_WB : ST_RDB;
      ST_RDB:  state_d = ST_EXEC;
      ST_EXEC: state_d = (fields_q.opcode == OP_CMP) ? ST_IDLE : ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Op fields are captured only on acceptance, so start during an op is ignored
  always_comb begin
    fields_d = fields_q;
    if (state_q == ST_IDLE && sif.start) begin
      fields_d.opcode = sif.opcode;
      fields_d.rd     = sif.rd;
      fields_d.rs1    = sif.rs1;
      fields_d.rs2    = sif.rs2;
      fields_d.imm    = sif.imm;
    end
  end

  // Count every legal completion; the register wraps on overflow
  always_comb begin
    opCount_d = opCount_q;
    if (ctl.done && !ctl.err) opCount_d = opCount_q + CNT_W'(1);
  end

  // Registers; reset also abandons any op in flight before its write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fields_q  <= '0;
      opCount_q <= '0;
    end else begin
      state_q   <= state_d;
      fields_q  <= fields_d;
      opCount_q <= opCount_d;
    end
  end

  regbus_ctl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (fields_q.opcode),
    .rd_i     (fields_q.rd),
    .rs1_i    (fields_q.rs1),
    .rs2_i    (fields_q.rs2),
    .ctl_o    (ctl)
  );

  assign sif.busy     = ctl.busy;
  assign sif.done     = ctl.done;
  assign sif.err      = ctl.err;
  assign sif.rsel     = ctl.rsel;
  assign sif.wrr      = ctl.wrr;
  assign sif.tr       = ctl.tr;
  assign sif.la       = ctl.la;
  assign sif.ta       = ctl.ta;
  assign sif.lb       = ctl.lb;
  assign sif.lz       = ctl.lz;
  assign sif.tz       = ctl.tz;
  assign sif.alu_t    = ctl.alu_t;
  assign sif.alu_op   = ctl.alu_op;
  assign sif.sflag    = ctl.sflag;
  assign sif.imm_t    = ctl.imm_t;
  assign sif.imm_out  = fields_q.imm;
  assign sif.op_count = opCount_q;

endmodule

// File: tb/tb_regbus_sequencer.sv
// Bench for regbus_sequencer: a bus datapath (bank, A, B, Z, ALU, flags) is
// steered by the DUT strobes, while an op-level reference model predicts the
// register/flag/count results, latency and done-cycle strobes of every op.
module tb_regbus_sequencer;
  import regbus_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regbus_sequencer_if sif();

  regbus_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  typedef struct packed {
    logic [2:0] rsel;
    logic wrr, tr, la, ta, lb, lz, tz, aluT, aluOp, sflag, immT;
  } doneCtl_t;

  typedef struct packed {
    logic             err;
    logic [3:0]       lat;
    doneCtl_t         ctl;
    logic [7:0][15:0] bank;
    logic [3:0]       flags;
    logic [15:0]      count;
  } exp_t;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Datapath environment driven purely by the DUT's strobes
  logic [7:0][15:0] envBank;
  logic [15:0]      envA, envB, envZ;
  logic [3:0]       envFlags;
  logic             envInit;
  logic [15:0]      busVal;
  int               driverCount;
  logic [16:0]      aluWide;
  logic             aluV;

  always_comb begin
    aluWide = sif.alu_op ? ({1'b0, envA} - {1'b0, envB}) : ({1'b0, envA} + {1'b0, envB});
    aluV    = sif.alu_op ? ((envA[15] != envB[15]) && (aluWide[15] != envA[15]))
                         : ((envA[15] == envB[15]) && (aluWide[15] != envA[15]));
    busVal      = '0;
    driverCount = 0;
    if (sif.tr)    begin busVal |= envBank[sif.rsel];  driverCount += 1; end
    if (sif.ta)    begin busVal |= envA;               driverCount += 1; end
    if (sif.tz)    begin busVal |= envZ;               driverCount += 1; end
    if (sif.alu_t) begin busVal |= aluWide[15:0];      driverCount += 1; end
    if (sif.imm_t) begin busVal |= sif.imm_out;        driverCount += 1; end
  end

  always_ff @(posedge clk) begin
    if (envInit) begin
      envBank  <= '0;
      envA     <= '0;
      envB     <= '0;
      envZ     <= '0;
      envFlags <= '0;
    end else begin
      if (sif.la)    envA <= busVal;
      if (sif.lb)    envB <= busVal;
      if (sif.lz)    envZ <= busVal;
      if (sif.wrr)   envBank[sif.rsel] <= busVal;
      if (sif.sflag) envFlags <= {aluWide[16], aluWide[15:0] == 16'h0, aluV, aluWide[15]};
    end
  end

  // Op-level reference model: flags are {C, Z, V, S}, C is borrow on subtract
  logic [7:0][15:0] refBank;
  logic [3:0]       refFlags;
  logic [15:0]      refCount;
  exp_t             expQ[$];

  function automatic exp_t modelOp(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                   input logic [2:0] rs2, input logic [15:0] imm);
    exp_t e;
    int a, b, sa, sb, r, sr;
    e  = '0;
    a  = int'(refBank[rs1]);
    b  = int'(refBank[rs2]);
    sa = $signed(refBank[rs1]);
    sb = $signed(refBank[rs2]);
    case (op)
      OP_LDI: begin
        refBank[rd] = imm;
        e.lat = 4'd1; e.ctl.rsel = rd; e.ctl.wrr = 1'b1; e.ctl.immT = 1'b1;
      end
      OP_MOV: begin
        refBank[rd] = refBank[rs1];
        e.lat = 4'd2; e.ctl.rsel = rd; e.ctl.wrr = 1'b1; e.ctl.ta = 1'b1;
      end
      OP_ADD: begin
        r  = a + b;
        sr = sa + sb;
        refFlags = {r > 65535, r[15:0] == 16'h0, (sr > 32767) || (sr < -32768), r[15]};
        refBank[rd] = r[15:0];
        e.lat = 4'd4; e.ctl.rsel = rd; e.ctl.wrr = 1'b1; e.ctl.tz = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        r  = a - b;
        sr = sa - sb;
        refFlags = {a < b, r[15:0] == 16'h0, (sr > 32767) || (sr < -32768), r[15]};
        if (op == OP_SUB) begin
          refBank[rd] = r[15:0];
          e.lat = 4'd4; e.ctl.rsel = rd; e.ctl.wrr = 1'b1; e.ctl.tz = 1'b1;
        end else begin
          e.lat = 4'd3; e.ctl.aluT = 1'b1; e.ctl.aluOp = 1'b1; e.ctl.lz = 1'b1; e.ctl.sflag = 1'b1;
        end
      end
      default: begin
        e.err = 1'b1;
        e.lat = 4'd1;
      end
    endcase
    if (!e.err) refCount = refCount + 16'd1;
    e.bank  = refBank;
    e.flags = refFlags;
    e.count = refCount;
    return e;
  endfunction

  function automatic doneCtl_t actCtl();
    doneCtl_t c;
    c.rsel = sif.rsel; c.wrr = sif.wrr; c.tr = sif.tr; c.la = sif.la; c.ta = sif.ta;
    c.lb = sif.lb; c.lz = sif.lz; c.tz = sif.tz; c.aluT = sif.alu_t; c.aluOp = sif.alu_op;
    c.sflag = sif.sflag; c.immT = sif.imm_t;
    return c;
  endfunction

  function automatic logic [63:0] outVec();
    return {sif.busy, sif.done, sif.err, actCtl(), sif.imm_out, sif.op_count};
  endfunction

  // Monitor: bus invariants every cycle, scoreboard pop on each done
  bit   postPending = 0;
  bit   inFlight    = 0;
  int   cyc         = 0;
  exp_t postExp;
  exp_t curExp;

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("one_bus_driver", driverCount <= 1, 1);
      checkOutput("err_only_with_done", sif.err && !sif.done, 0);
      checkOutput("wrr_only_in_wb", sif.wrr && !(sif.done && !sif.err), 0);
      if (postPending) begin
        for (int i = 0; i < 8; i++)
          checkOutput($sformatf("bank_r%0d", i), envBank[i], postExp.bank[i]);
        checkOutput("flags", envFlags, postExp.flags);
        checkOutput("op_count", sif.op_count, postExp.count);
        postPending = 0;
      end
      if (reset) begin
        inFlight = 0;
      end else begin
        if (inFlight) cyc++;
        if (sif.done) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            curExp = expQ.pop_front();
            checkOutput("latency", inFlight ? cyc : 99, curExp.lat);
            checkOutput("err_pulse", sif.err, curExp.err);
            checkOutput("done_controls", actCtl(), curExp.ctl);
            postExp     = curExp;
            postPending = 1;
          end
          inFlight = 0;
        end
        if (!sif.busy && sif.start) begin
          inFlight = 1;
          cyc      = 0;
        end
      end
    end
  end

  // Issue one op; optionally hold start (with scrambled fields) until done
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic [15:0] imm, input bit hold);
    int guard = 0;
    while (sif.busy && guard < 20) begin @(posedge clk); #1; guard++; end
    if (sif.busy) checkOutput("idle_before_issue", sif.busy, 0);
    sif.opcode = op; sif.rd = rd; sif.rs1 = rs1; sif.rs2 = rs2; sif.imm = imm;
    sif.start  = 1'b1;
    expQ.push_back(modelOp(op, rd, rs1, rs2, imm));
    @(posedge clk); #1;
    if (hold) begin
      sif.opcode = 3'($urandom_range(0, 7));
      sif.rd     = 3'($urandom_range(0, 7));
      sif.imm    = 16'($urandom);
      guard = 0;
      while (!sif.done && guard < 20) begin @(posedge clk); #1; guard++; end
    end
    sif.start = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((expQ.size() != 0 || postPending || sif.busy) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput("drain_in_time", guard < 50, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; envInit = 1'b1;
    sif.start = 1'b0; sif.opcode = '0; sif.rd = '0; sif.rs1 = '0; sif.rs2 = '0; sif.imm = '0;
    refBank = '0; refFlags = '0; refCount = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; envInit = 1'b0;
    checkOutput("reset_outputs_zero", outVec(), 64'h0);

    applyStimulus(OP_LDI, 3'd3, 3'd0, 3'd0, 16'h1234, 0);
    waitDrain();
    checkOutput("ldi_r3", envBank[3], 16'h1234);
    checkOutput("ldi_count", sif.op_count, 16'd1);

    applyStimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h7FFF, 0);
    applyStimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 0);
    applyStimulus(OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0000, 0);
    waitDrain();
    checkOutput("add_r4", envBank[4], 16'h8000);
    checkOutput("add_flags_czvs", envFlags, 4'b0011);

    applyStimulus(OP_CMP, 3'd0, 3'd4, 3'd4, 16'h0000, 0);
    waitDrain();
    checkOutput("cmp_flags_czvs", envFlags, 4'b0100);
    checkOutput("cmp_r4_kept", envBank[4], 16'h8000);

    applyStimulus(OP_MOV, 3'd5, 3'd3, 3'd0, 16'h0000, 0);
    waitDrain();
    checkOutput("mov_r5", envBank[5], 16'h1234);

    applyStimulus(3'b111, 3'd6, 3'd1, 3'd2, 16'hFFFF, 1);
    waitDrain();
    checkOutput("illegal_count_kept", sif.op_count, 16'd6);

    applyStimulus(OP_ADD, 3'd6, 3'd1, 3'd2, 16'h0000, 1);
    waitDrain();
    checkOutput("held_start_count", sif.op_count, 16'd7);

    // Abort a SUB while it sits in RDB
    sif.opcode = OP_SUB; sif.rd = 3'd6; sif.rs1 = 3'd4; sif.rs2 = 3'd3; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_in_rdb", {sif.tr, sif.lb, sif.rsel}, {1'b1, 1'b1, 3'd3});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    refCount = '0;
    checkOutput("abort_outputs_zero", outVec(), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_stays_idle", sif.busy, 0);
    checkOutput("abort_no_write", envBank[6], refBank[6]);

    applyStimulus(OP_LDI, 3'd7, 3'd0, 3'd0, 16'hBEEF, 0);
    waitDrain();
    checkOutput("post_abort_ldi", envBank[7], 16'hBEEF);
    checkOutput("post_abort_count", sif.op_count, 16'd1);

    for (int n = 0; n < 60; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 7) == 0);
    end
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
